// File: rtl/can_pkg.sv
// Shared CAN definitions: field widths, scheduler state encoding and
// the mailbox priority selector used by the transmit scheduler.
package can_pkg;
    localparam int ID_W     = 11;
    localparam int DLC_W    = 4;
    localparam int DATA_W   = 64;
    localparam int MAX_MBOX = 8;
    localparam int IDX_W    = 3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_BUS = 3'd1,
        S_SELECT   = 3'd2,
        S_START    = 3'd3,
        S_BUSY     = 3'd4,
        S_GAP      = 3'd5
    } sched_state_t;

    // Lowest ID wins; the strict compare keeps the lower index on a tie.
    function automatic logic [IDX_W-1:0] min_id_index(
        input logic [MAX_MBOX*ID_W-1:0] ids,
        input logic [MAX_MBOX-1:0]      req
    );
        logic [IDX_W-1:0] best_idx;
        logic [ID_W-1:0]  best_id;
        logic             found;
        best_idx = {IDX_W{1'b0}};
        best_id  = {ID_W{1'b1}};
        found    = 1'b0;
        for (int k = 0; k < MAX_MBOX; k++) begin
            if (req[k] && (!found || (ids[k*ID_W +: ID_W] < best_id))) begin
                best_idx = IDX_W'(k);
                best_id  = ids[k*ID_W +: ID_W];
                found    = 1'b1;
            end
        end
        return best_idx;
    endfunction
endpackage

// File: rtl/can_bus_idle.sv
// Bus-idle detector: samples the bus once per bit time and reports idle
// after IDLE_BITS consecutive recessive samples.
module can_bus_idle #(
    parameter int CLKS_PER_BIT = 10,
    parameter int IDLE_BITS    = 11
) (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic i_Bus_Serial,
    output logic o_Bus_Idle
);
    localparam int PH_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CNT_W = $clog2(IDLE_BITS + 1);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(CLKS_PER_BIT - 1);
    localparam logic [PH_W-1:0]  PH_SAMPLE = PH_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(IDLE_BITS);

    logic [PH_W-1:0]  phase_r;
    logic [CNT_W-1:0] rec_cnt_r;
    logic [CNT_W-1:0] rec_cnt_nxt_s;
    logic             idle_r;

    // Recessive-run count: cleared by a dominant sample, saturating at IDLE_BITS
    always_comb begin
        rec_cnt_nxt_s = rec_cnt_r;
        if (phase_r == PH_SAMPLE) begin
            if (!i_Bus_Serial) begin
                rec_cnt_nxt_s = {CNT_W{1'b0}};
            end else if (rec_cnt_r != CNT_MAX) begin
                rec_cnt_nxt_s = rec_cnt_r + CNT_W'(1);
            end else begin
                rec_cnt_nxt_s = rec_cnt_r;
            end
        end else begin
            rec_cnt_nxt_s = rec_cnt_r;
        end
    end

    // Free-running bit-phase counter
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            phase_r <= {PH_W{1'b0}};
        end else if (phase_r == PH_LAST) begin
            phase_r <= {PH_W{1'b0}};
        end else begin
            phase_r <= phase_r + PH_W'(1);
        end
    end

    // Recessive counter and registered idle flag
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rec_cnt_r <= {CNT_W{1'b0}};
            idle_r    <= 1'b0;
        end else begin
            rec_cnt_r <= rec_cnt_nxt_s;
            idle_r    <= (rec_cnt_nxt_s == CNT_MAX);
        end
    end

    assign o_Bus_Idle = idle_r;
endmodule

// File: rtl/can_tx_sched.sv
// Transmit scheduler: shares one can_tx among N_MBOX mailboxes, granting the
// lowest pending ID once the bus is idle and retrying failed attempts.
module can_tx_sched
    import can_pkg::*;
#(
    parameter int N_MBOX       = 4,
    parameter int CLKS_PER_BIT = 10,
    parameter int IDLE_BITS    = 11,
    parameter int MAX_RETRY    = 8
) (
    input  logic                       i_Clock,
    input  logic                       i_Rst_n,
    input  logic [N_MBOX-1:0]          i_Req,
    input  logic [ID_W*N_MBOX-1:0]     i_Id,
    input  logic [DLC_W*N_MBOX-1:0]    i_Dlc,
    input  logic [DATA_W*N_MBOX-1:0]   i_Data,
    input  logic                       i_Bus_Serial,
    output logic                       o_Tx_Start,
    output logic [ID_W-1:0]            o_Tx_Id,
    output logic [DLC_W-1:0]           o_Tx_Dlc,
    output logic [DATA_W-1:0]          o_Tx_Data,
    input  logic                       i_Tx_Done,
    input  logic                       i_Tx_Arb_Lost,
    input  logic                       i_Tx_Err,
    output logic [N_MBOX-1:0]          o_Grant,
    output logic [N_MBOX-1:0]          o_Done,
    output logic [N_MBOX-1:0]          o_Abort,
    output logic                       o_Busy
);
    localparam int RTY_W = $clog2(MAX_RETRY + 2);
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);

    sched_state_t              state_r;
    sched_state_t              next_state_s;
    logic                      bus_idle_s;
    logic [MAX_MBOX*ID_W-1:0]  ids_ext_s;
    logic [MAX_MBOX-1:0]       req_ext_s;
    logic [IDX_W-1:0]          sel_idx_s;
    logic [N_MBOX-1:0]         sel_grant_s;
    logic [IDX_W-1:0]          win_idx_r;
    logic [RTY_W-1:0]          retry_r;
    logic [RTY_W-1:0]          retry_nxt_s;
    logic [RTY_W-1:0]          retry_inc_s;
    logic                      done_ev_s;
    logic                      abort_ev_s;
    logic [N_MBOX-1:0]         grant_r;
    logic [N_MBOX-1:0]         done_r;
    logic [N_MBOX-1:0]         abort_r;
    logic                      tx_start_r;
    logic                      busy_r;
    logic [ID_W-1:0]           tx_id_r;
    logic [DLC_W-1:0]          tx_dlc_r;
    logic [DATA_W-1:0]         tx_data_r;

    can_bus_idle #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .IDLE_BITS    (IDLE_BITS)
    ) u_bus_idle (
        .i_Clock      (i_Clock),
        .i_Rst_n      (i_Rst_n),
        .i_Bus_Serial (i_Bus_Serial),
        .o_Bus_Idle   (bus_idle_s)
    );

    // Widen mailbox IDs/requests to the selector's fixed width
    always_comb begin
        ids_ext_s = {(MAX_MBOX*ID_W){1'b0}};
        req_ext_s = {MAX_MBOX{1'b0}};
        ids_ext_s[N_MBOX*ID_W-1:0] = i_Id;
        req_ext_s[N_MBOX-1:0]      = i_Req;
    end

    assign sel_idx_s   = min_id_index(ids_ext_s, req_ext_s);
    assign sel_grant_s = {{(N_MBOX-1){1'b0}}, 1'b1} << sel_idx_s;
    assign retry_inc_s = retry_r + RTY_W'(1);

    // Next-state, retry update and outcome events
    always_comb begin
        next_state_s = state_r;
        retry_nxt_s  = retry_r;
        done_ev_s    = 1'b0;
        abort_ev_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (|i_Req) next_state_s = S_WAIT_BUS;
                else        next_state_s = S_IDLE;
            end
            S_WAIT_BUS: begin
                if (!(|i_Req))    next_state_s = S_IDLE;
                else if (bus_idle_s) next_state_s = S_SELECT;
                else              next_state_s = S_WAIT_BUS;
            end
            S_SELECT: begin
                // A request withdrawn during selection leaves nothing to send
                if (|i_Req) begin
                    next_state_s = S_START;
                    if (sel_idx_s != win_idx_r) retry_nxt_s = {RTY_W{1'b0}};
                    else                        retry_nxt_s = retry_r;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_START: next_state_s = S_BUSY;
            S_BUSY: begin
                if (i_Tx_Err) begin
                    if (retry_inc_s > RTY_MAX) begin
                        abort_ev_s   = 1'b1;
                        retry_nxt_s  = {RTY_W{1'b0}};
                        next_state_s = S_GAP;
                    end else begin
                        retry_nxt_s  = retry_inc_s;
                        next_state_s = S_WAIT_BUS;
                    end
                end else if (i_Tx_Arb_Lost) begin
                    next_state_s = S_WAIT_BUS;
                end else if (i_Tx_Done) begin
                    done_ev_s    = 1'b1;
                    retry_nxt_s  = {RTY_W{1'b0}};
                    next_state_s = S_GAP;
                end else begin
                    next_state_s = S_BUSY;
                end
            end
            S_GAP:   next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) state_r <= S_IDLE;
        else          state_r <= next_state_s;
    end

    // Registered outputs, latched frame and retry bookkeeping
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            tx_start_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= {N_MBOX{1'b0}};
            abort_r    <= {N_MBOX{1'b0}};
            grant_r    <= {N_MBOX{1'b0}};
            win_idx_r  <= {IDX_W{1'b0}};
            retry_r    <= {RTY_W{1'b0}};
            tx_id_r    <= {ID_W{1'b0}};
            tx_dlc_r   <= {DLC_W{1'b0}};
            tx_data_r  <= {DATA_W{1'b0}};
        end else begin
            tx_start_r <= (next_state_s == S_START);
            busy_r     <= (next_state_s != S_IDLE);
            done_r     <= done_ev_s  ? grant_r : {N_MBOX{1'b0}};
            abort_r    <= abort_ev_s ? grant_r : {N_MBOX{1'b0}};
            retry_r    <= retry_nxt_s;
            if ((state_r == S_SELECT) && (next_state_s == S_START)) begin
                grant_r   <= sel_grant_s;
                win_idx_r <= sel_idx_s;
                tx_id_r   <= i_Id[int'(sel_idx_s)*ID_W +: ID_W];
                tx_dlc_r  <= i_Dlc[int'(sel_idx_s)*DLC_W +: DLC_W];
                tx_data_r <= i_Data[int'(sel_idx_s)*DATA_W +: DATA_W];
            end else if ((next_state_s == S_GAP) || (next_state_s == S_IDLE)) begin
                grant_r <= {N_MBOX{1'b0}};
            end
        end
    end

    assign o_Tx_Start = tx_start_r;
    assign o_Tx_Id    = tx_id_r;
    assign o_Tx_Dlc   = tx_dlc_r;
    assign o_Tx_Data  = tx_data_r;
    assign o_Grant    = grant_r;
    assign o_Done     = done_r;
    assign o_Abort    = abort_r;
    assign o_Busy     = busy_r;
endmodule

// File: doc/can_tx_sched.md
Name: can_tx_sched

Overview:
- Transmit scheduler sharing one can_tx serializer among N_MBOX transmit mailboxes.
- Waits for bus idle, then grants the pending mailbox with the highest CAN priority (lowest 11-bit ID) and launches can_tx.
- Tracks the attempt outcome (ACK ok, arbitration lost, error) and retries up to MAX_RETRY times before aborting.
- Sits between host-side mailbox registers and can_tx; monitors the bus through the same serial line that feeds can_rx.

Parameters:
- N_MBOX, 4, number of mailboxes (2..8).
- CLKS_PER_BIT, 10, clocks per CAN bit, as in can_tx/can_rx.
- IDLE_BITS, 11, consecutive recessive bits required before the bus counts as idle.
- MAX_RETRY, 8, failed attempts allowed per frame before abort.

Ports:
- i_Clock  in  1  system clock.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_Req  in  N_MBOX  level request per mailbox; held until o_Done or o_Abort.
- i_Id  in  11*N_MBOX  packed IDs; mailbox k is at bits [11k+10:11k].
- i_Dlc  in  4*N_MBOX  packed DLCs.
- i_Data  in  64*N_MBOX  packed payloads.
- i_Bus_Serial  in  1  sampled CAN bus (1 = recessive).
- o_Tx_Start  out  1  one-cycle pulse to can_tx.
- o_Tx_Id  out  11  ID of the granted frame, stable from start to result.
- o_Tx_Dlc  out  4  DLC of the granted frame.
- o_Tx_Data  out  64  payload of the granted frame.
- i_Tx_Done  in  1  can_tx pulse: frame completed, ACK received.
- i_Tx_Arb_Lost  in  1  can_tx pulse: arbitration lost.
- i_Tx_Err  in  1  pulse: stuff, form, or ACK error (can_stuff_error or can_tx).
- o_Grant  out  N_MBOX  one-hot grant of the current attempt; 0 when idle.
- o_Done  out  N_MBOX  one-cycle success pulse per mailbox.
- o_Abort  out  N_MBOX  one-cycle pulse when the retry limit is exceeded.
- o_Busy  out  1  high in every state except S_IDLE.

Behaviour:
- Reset (async, i_Rst_n=0):
  - state=S_IDLE.
  - All outputs 0; o_Tx_Id/o_Tx_Dlc/o_Tx_Data = 0.
  - Idle bit counter and retry counter = 0.
  - A reset during S_BUSY drops the attempt silently; no o_Done or o_Abort.
- Bus-idle detector:
  - Bit-time sampler at CLKS_PER_BIT/2 of each bit.
  - Counts consecutive recessive samples and saturates at IDLE_BITS.
  - Any dominant sample clears the count.
  - bus_idle = (count == IDLE_BITS). The detector runs in all states.
- FSM:
  - S_IDLE: if |i_Req, go to S_WAIT_BUS.
  - S_WAIT_BUS: if i_Req drops to 0, go to S_IDLE. If bus_idle, go to S_SELECT.
  - S_SELECT (1 cycle):
    - Pick the requesting mailbox with the minimum ID; an ID tie goes to the lower index.
    - Latch its ID/DLC/data onto the o_Tx_* outputs.
    - Set o_Grant one-hot. If the winner differs from the previous attempt's winner, clear the retry counter.
    - Go to S_START.
  - S_START (1 cycle): o_Tx_Start=1, go to S_BUSY.
  - S_BUSY: wait for an outcome pulse.
    - i_Tx_Done: o_Done[g]=1 next cycle, clear retry, go to S_GAP.
    - i_Tx_Arb_Lost: no retry increment, go to S_WAIT_BUS.
    - i_Tx_Err: retry+1. If the new value > MAX_RETRY, o_Abort[g]=1, clear retry, go to S_GAP; else go to S_WAIT_BUS.
    - Simultaneous pulses resolve by priority Err > Arb_Lost > Done.
  - S_GAP (1 cycle): o_Grant=0, go to S_IDLE. This gives the host one cycle to drop i_Req.
- Latency: bus_idle to o_Tx_Start is 2 cycles (SELECT, START).
- o_Tx_* outputs hold their last values outside S_BUSY.
- If i_Req[g] drops during S_BUSY, the attempt continues; its outcome pulse is still issued.
- Requests are re-evaluated at every S_SELECT. A higher-priority request arriving after a retry therefore preempts the retried frame, and the retry counter is cleared.
- Retry counter width is clog2(MAX_RETRY+2).

Decomposition:
- Shared package can_pkg:
  - ID_W=11, DLC_W=4, DATA_W=64.
  - FSM state encodings.
  - Function min_id_index(ids, req).
- Sub-module can_bus_idle (sampler plus recessive counter): parameters CLKS_PER_BIT and IDLE_BITS; ports i_Clock, i_Rst_n, i_Bus_Serial, o_Bus_Idle.

Test Plan:
- Single request: i_Req=0001, ID 0x123, bus recessive for 11 bits → o_Tx_Start 2 cycles after bus_idle; o_Tx_Id=0x123; i_Tx_Done → o_Done=0001; o_Busy returns to 0.
- Priority: i_Req=1110 with IDs {m1=0x200, m2=0x050, m3=0x050} → grant 0100 (0x050, lower index); then after Done, 1000, then 0010.
- Bus busy: i_Bus_Serial toggles dominant every 5 bits → no o_Tx_Start. After 11 recessive bits → start; a dominant bit at recessive bit 10 restarts the count.
- Arbitration loss: i_Tx_Arb_Lost during the first attempt → back to S_WAIT_BUS, retry stays 0, same mailbox restarted, later o_Done.
- Retry limit: MAX_RETRY=8; i_Tx_Err on every attempt → 9 o_Tx_Start pulses, then o_Abort on that mailbox, no o_Done.
- Reset mid-frame: i_Rst_n low in S_BUSY → all outputs 0 immediately (asynchronous); after release with i_Req still high, a new attempt starts after 11 idle bits.
